la_wb_initiator: RTL and testbench

Wishbone classic initiator that lets the management firmware, via logic-analyzer bits adapted by the wrapper, issue single read/write cycles into a wrapped project's Wishbone responder port. It accepts one command at a time over a valid/ready handshake, runs one Wishbone cycle, and returns read data or a timeout error over a second valid/ready handshake. It sits inside the user project area between the LA glue and the project-side `wbs_*` bus.

---
 rtl/la_wb_pkg.sv | 8 +
 rtl/wb_timeout_timer.sv | 22 ++
 rtl/la_wb_initiator.sv | 85 ++++++++
 tb/tb_la_wb_initiator.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/la_wb_pkg.sv
// la_wb_pkg: shared types and widths for the LA-driven Wishbone initiator.
package la_wb_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam logic [WB_DAT_W-1:0] RSP_ERR_DAT = 32'h0;
endpackage

// File: rtl/wb_timeout_timer.sv
// wb_timeout_timer: saturating stall counter; expired marks the cycle the limit is reached.
module wb_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
    logic [W-1:0] count;
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni || clear)
            count <= '0;
        else if (enable && count != LIMIT)
            count <= count + 1'b1;
    end
    // this stalled cycle is the last one allowed, so the bus cycle ends here
    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT - 1'b1);
endmodule

// File: rtl/la_wb_initiator.sv
// la_wb_initiator: runs one Wishbone classic cycle per command and returns data or a timeout error.
module la_wb_initiator
    import la_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic                wbm_ack_i,
    input  logic [WB_DAT_W-1:0] wbm_dat_i
);
    state_t state, next;
    logic accept, expired, done;

    assign accept = (state == IDLE) && cmd_valid_i;
    assign done   = (state == BUS) && (wbm_ack_i || expired);

    wb_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) timer (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .clear    (accept),
        .enable   ((state == BUS) && !wbm_ack_i),
        .expired  (expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        if (accept)
            next = BUS;
        if (done)
            next = RESP;
        if (state == RESP && rsp_ready_i)
            next = IDLE;
        cmd_ready_o = (state == IDLE);
        wbm_cyc_o   = (state == BUS);
        wbm_stb_o   = (state == BUS);
        rsp_valid_o = (state == RESP);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat_o <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            if (accept) begin
                wbm_we_o  <= cmd_we_i;
                wbm_sel_o <= cmd_sel_i;
                wbm_adr_o <= cmd_adr_i;
                wbm_dat_o <= cmd_dat_i;
            end
            // ack beats a simultaneous timeout
            if (done) begin
                rsp_dat_o <= wbm_ack_i ? (wbm_we_o ? '0 : wbm_dat_i) : RSP_ERR_DAT;
                rsp_err_o <= !wbm_ack_i;
            end
        end
    end
endmodule

// File: tb/tb_la_wb_initiator.sv
// tb_la_wb_initiator: randomized scoreboard bench with a responder model and decoupled response monitor.
module tb_la_wb_initiator;
    localparam int T = 8;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        int          w;
    } plan_t;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        int          stb;
    } exp_t;

    logic        wb_clk_i = 0, wb_rst_ni = 0;
    logic        cmd_valid_i = 0, cmd_ready_o, cmd_we_i = 0;
    logic [3:0]  cmd_sel_i = 0;
    logic [31:0] cmd_adr_i = 0, cmd_dat_i = 0;
    logic        rsp_valid_o, rsp_ready_i = 0, rsp_err_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i = 0;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = 0;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    total = 0, passed = 0;

    la_wb_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_sel_i(cmd_sel_i), .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    task automatic do_cmd(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [31:0] rdata, input int w,
                          input bit scored);
        plan_t p;
        exp_t  e;
        int    n = 0;
        p = '{we, sel, adr, dat, rdata, w};
        cmd_we_i = we;
        cmd_sel_i = sel;
        cmd_adr_i = adr;
        cmd_dat_i = dat;
        cmd_valid_i = 1;
        while (!cmd_ready_o && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (!cmd_ready_o) begin
            total++;
            $display("FAIL accept_wait: cmd_ready_o stuck at 0 after %0d cycles", n);
            cmd_valid_i = 0;
            return;
        end
        plan_q.push_back(p);
        if (scored) begin
            e.err = (w >= T);
            e.dat = (we || e.err) ? 32'h0 : rdata;
            e.stb = e.err ? T : w + 1;
            exp_q.push_back(e);
        end
        @(negedge wb_clk_i);
        cmd_valid_i = 0;
        chk("cyc_stb_after_accept", {wbm_cyc_o, wbm_stb_o}, 2'b11);
    endtask

    // responder: follows the wait plan during BUS, sprays stray acks otherwise
    initial begin
        plan_t cur;
        int    bus_cnt = 0;
        cur = '{0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_ni) begin
                bus_cnt = 0;
                wbm_ack_i = 1;
                wbm_dat_i = $urandom;
            end else if (wbm_stb_o) begin
                if (bus_cnt == 0) begin
                    if (plan_q.size() == 0) begin
                        total++;
                        $display("FAIL unplanned_bus_cycle: stb=1 expected stb=0");
                    end else
                        cur = plan_q.pop_front();
                end
                chk("wbm_we", wbm_we_o, cur.we);
                chk("wbm_sel", wbm_sel_o, cur.sel);
                chk("wbm_adr", wbm_adr_o, cur.adr);
                chk("wbm_dat", wbm_dat_o, cur.dat);
                wbm_ack_i = (bus_cnt == cur.w);
                wbm_dat_i = cur.rdata;
                bus_cnt++;
            end else begin
                bus_cnt = 0;
                wbm_ack_i = ($urandom_range(0, 2) == 0);
                wbm_dat_i = $urandom;
            end
        end
    end

    // monitor: scores each response and applies random backpressure
    initial begin
        exp_t cur;
        int   stb_cnt = 0, hold = 0;
        bit   in_resp = 0, consumed = 0, prev_stb = 0;
        cur = '{0, 0, 0};
        forever begin
            @(negedge wb_clk_i);
            if (!wb_rst_ni) begin
                stb_cnt = 0;
                in_resp = 0;
                consumed = 0;
                prev_stb = 0;
                rsp_ready_i = 0;
                continue;
            end
            if (consumed) begin
                chk("rsp_valid_after_consume", rsp_valid_o, 0);
                chk("cmd_ready_after_consume", cmd_ready_o, 1);
                consumed = 0;
                in_resp = 0;
            end
            if (rsp_valid_o) begin
                chk("cmd_ready_in_resp", cmd_ready_o, 0);
                if (!in_resp) begin
                    in_resp = 1;
                    hold = $urandom_range(0, 5);
                    chk("stb_right_before_rsp", prev_stb, 1);
                    if (exp_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_rsp: rsp_valid_o=1 expected 0");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("stb_cycles", stb_cnt, cur.stb);
                    end
                    stb_cnt = 0;
                end
                chk("rsp_dat", rsp_dat_o, cur.dat);
                chk("rsp_err", rsp_err_o, cur.err);
                if (hold == 0) begin
                    rsp_ready_i = 1;
                    consumed = 1;
                end else begin
                    hold--;
                    rsp_ready_i = 0;
                end
            end else
                rsp_ready_i = 0;
            if (wbm_stb_o)
                stb_cnt++;
            prev_stb = wbm_stb_o;
        end
    end

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid_o) && n < 500) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n == 500) begin
            total++;
            $display("FAIL drain: %0d responses still pending expected 0", exp_q.size());
        end
        repeat (2) @(negedge wb_clk_i);
    endtask

    initial begin
        repeat (2) @(negedge wb_clk_i);
        chk("rst_cmd_ready", cmd_ready_o, 1);
        chk("rst_ctl", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, rsp_valid_o, rsp_err_o}, 0);
        chk("rst_adr", wbm_adr_o, 0);
        chk("rst_wdat", wbm_dat_o, 0);
        chk("rst_rdat", rsp_dat_o, 0);
        wb_rst_ni = 1;
        @(negedge wb_clk_i);
        do_cmd(0, 4'hf, 32'h3000_0004, 32'h0, 32'hA5A5_1234, 0, 1);
        do_cmd(1, 4'b0011, 32'h3000_0010, 32'hCAFE_F00D, 32'h1111_2222, 3, 1);
        do_cmd(0, 4'hf, 32'h3000_0020, 32'h0, 32'hDEAD_BEEF, 1000, 1);
        do_cmd(0, 4'hf, 32'h3000_0024, 32'h0, 32'h0BAD_CAFE, T - 1, 1);
        for (int i = 0; i < 60; i++) begin
            do_cmd($urandom_range(0, 1), 4'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 5) == 0) ? 1000 : $urandom_range(0, 9), 1);
            repeat ($urandom_range(0, 2)) @(negedge wb_clk_i);
        end
        drain();
        do_cmd(0, 4'hf, 32'h3000_0040, 32'h0, 32'h5555_AAAA, 1000, 0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 0;
        @(negedge wb_clk_i);
        wb_rst_ni = 1;
        chk("rst_mid_cyc_stb", {wbm_cyc_o, wbm_stb_o}, 0);
        chk("rst_mid_rsp_valid", rsp_valid_o, 0);
        chk("rst_mid_cmd_ready", cmd_ready_o, 1);
        for (int i = 0; i < T + 2; i++) begin
            @(negedge wb_clk_i);
            chk("post_rst_quiet", {wbm_stb_o, rsp_valid_o}, 0);
        end
        do_cmd(0, 4'hf, 32'h3000_0044, 32'h0, 32'h1234_5678, 2, 1);
        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
